// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        XFER   = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam logic OWN_INERT = 1'b0;
    localparam logic OWN_A2D   = 1'b1;

    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/spi_arb_pick.sv
// Priority select between the two requesters, with an anti-starvation counter
// that hands the grant to A2D after MAX_INERT_CONSEC back-to-back inertial wins.
module spi_arb_pick
    import spi_arb_pkg::*;
#(
    parameter int MAX_INERT_CONSEC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inert_pend,
    input  logic a2d_pend,
    input  logic grant,
    output logic winner
);

    localparam int CW = (MAX_INERT_CONSEC > 0) ? $clog2(MAX_INERT_CONSEC + 1) : 1;
    localparam logic [CW-1:0] STARVE_MAX = CW'(MAX_INERT_CONSEC);

    logic [CW-1:0] starve_reg;

    assign winner = (a2d_pend && (!inert_pend || starve_reg == STARVE_MAX)) ? OWN_A2D : OWN_INERT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_reg <= '0;
        end else if (!a2d_pend || (grant && winner == OWN_A2D)) begin
            starve_reg <= '0;
        end else if (grant && starve_reg != STARVE_MAX) begin
            starve_reg <= starve_reg + 1'b1;
        end
    end

endmodule

// File: rtl/spi_arb.sv
// Shares one SPI master between the inertial and A2D interfaces: launch, wait, return, gap.
// Optional XFER watchdog is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int GAP_CYC          = 4,
    parameter int MAX_INERT_CONSEC = 4,
    parameter int TIMEOUT_CYC      = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inert_req,
    input  logic [15:0] inert_cmd,
    output logic        inert_done,
    input  logic        a2d_req,
    input  logic [15:0] a2d_cmd,
    output logic        a2d_done,
    output logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data,
    input  logic        spi_SS_n,
    output logic        INERT_SS_n,
    output logic        A2D_SS_n,
    input  logic        INERT_MISO,
    input  logic        A2D_MISO,
    output logic        spi_MISO,
    output logic        owner,
    output logic        busy,
    output logic        err
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam state_t AFTER_XFER = (GAP_CYC > 0) ? GAP : IDLE;

    state_t        state_reg;
    logic          owner_reg;
    logic          wrt_reg;
    logic [15:0]   cmd_reg;
    logic [15:0]   rd_data_reg;
    logic          inert_done_reg;
    logic          a2d_done_reg;
    logic [GW-1:0] gap_cnt_reg;

    logic [1:0]    pend_reg;
    logic [15:0]   cmd_lat_reg [2];
    logic [1:0]    req_vec;
    logic [15:0]   cmd_in [2];
    logic [1:0]    set_vec;
    logic [1:0]    clr_vec;

    logic active;
    logic grant;
    logic winner;

    assign active  = (state_reg == LAUNCH) || (state_reg == XFER);
    assign grant   = (state_reg == IDLE) && (|pend_reg);
    assign req_vec = {a2d_req, inert_req};
    assign cmd_in[0] = inert_cmd;
    assign cmd_in[1] = a2d_cmd;

    // The owner of an in-flight transfer cannot queue a second request behind itself.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign clr_vec[gi] = (state_reg == LAUNCH) && (owner_reg == 1'(gi));
            assign set_vec[gi] = req_vec[gi] && !pend_reg[gi] && !(active && owner_reg == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg <= '0;
            for (int i = 0; i < 2; i++) cmd_lat_reg[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (clr_vec[i]) begin
                    pend_reg[i] <= 1'b0;
                end else if (set_vec[i]) begin
                    pend_reg[i]    <= 1'b1;
                    cmd_lat_reg[i] <= cmd_in[i];
                end
            end
        end
    end

    spi_arb_pick #(
        .MAX_INERT_CONSEC(MAX_INERT_CONSEC)
    ) u_pick (
        .clk       (clk),
        .rst_n     (rst_n),
        .inert_pend(pend_reg[0]),
        .a2d_pend  (pend_reg[1]),
        .grant     (grant),
        .winner    (winner)
    );

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] wd_cnt_reg;
    logic          err_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            owner_reg      <= OWN_INERT;
            wrt_reg        <= 1'b0;
            cmd_reg        <= '0;
            rd_data_reg    <= '0;
            inert_done_reg <= 1'b0;
            a2d_done_reg   <= 1'b0;
            gap_cnt_reg    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            wd_cnt_reg     <= '0;
            err_reg        <= 1'b0;
`endif
        end else begin
            wrt_reg        <= 1'b0;
            inert_done_reg <= 1'b0;
            a2d_done_reg   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            err_reg        <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (grant) begin
                        owner_reg <= winner;
                        cmd_reg   <= cmd_lat_reg[winner];
                        wrt_reg   <= 1'b1;
                        state_reg <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    state_reg <= XFER;
`ifdef SPI_ARB_TIMEOUT_EN
                    wd_cnt_reg <= '0;
`endif
                end
                XFER: begin
                    if (spi_done) begin
                        rd_data_reg    <= spi_rd_data;
                        inert_done_reg <= (owner_reg == OWN_INERT);
                        a2d_done_reg   <= (owner_reg == OWN_A2D);
                        gap_cnt_reg    <= '0;
                        state_reg      <= AFTER_XFER;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (wd_cnt_reg == WD_LAST) begin
                        rd_data_reg    <= TIMEOUT_DATA;
                        inert_done_reg <= (owner_reg == OWN_INERT);
                        a2d_done_reg   <= (owner_reg == OWN_A2D);
                        err_reg        <= 1'b1;
                        gap_cnt_reg    <= '0;
                        state_reg      <= AFTER_XFER;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 1'b1;
                    end
`endif
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign wrt        = wrt_reg;
    assign cmd        = cmd_reg;
    assign rd_data    = rd_data_reg;
    assign inert_done = inert_done_reg;
    assign a2d_done   = a2d_done_reg;
    assign owner      = owner_reg;
    assign busy       = (state_reg != IDLE);

    // Slave selects only follow the master while a frame is actually on the wire.
    assign INERT_SS_n = (active && owner_reg == OWN_INERT) ? spi_SS_n : 1'b1;
    assign A2D_SS_n   = (active && owner_reg == OWN_A2D)   ? spi_SS_n : 1'b1;
    assign spi_MISO   = owner_reg ? A2D_MISO : INERT_MISO;

`ifdef SPI_ARB_TIMEOUT_EN
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_arb.sv
// Self-checking bench for spi_arb: directed vector table, hand-written corner
// sequences, then randomized traffic against a cycle-arithmetic reference model.
module tb_spi_arb;

    localparam int GAP  = 4;
    localparam int MAXC = 4;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TOUT     = 16;
    localparam int LONG_LAT = 12;
`else
    localparam int TOUT     = 4096;
    localparam int LONG_LAT = 32;
`endif
    localparam longint BIG = 64'd1000000000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inert_req, a2d_req, spi_done, spi_SS_n, INERT_MISO, A2D_MISO;
    logic [15:0] inert_cmd, a2d_cmd, spi_rd_data;
    logic        inert_done, a2d_done, wrt, INERT_SS_n, A2D_SS_n, spi_MISO, owner, busy, err;
    logic [15:0] rd_data, cmd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_arb #(
        .GAP_CYC(GAP), .MAX_INERT_CONSEC(MAXC), .TIMEOUT_CYC(TOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .inert_req(inert_req), .inert_cmd(inert_cmd), .inert_done(inert_done),
        .a2d_req(a2d_req), .a2d_cmd(a2d_cmd), .a2d_done(a2d_done),
        .rd_data(rd_data), .wrt(wrt), .cmd(cmd),
        .spi_done(spi_done), .spi_rd_data(spi_rd_data), .spi_SS_n(spi_SS_n),
        .INERT_SS_n(INERT_SS_n), .A2D_SS_n(A2D_SS_n),
        .INERT_MISO(INERT_MISO), .A2D_MISO(A2D_MISO), .spi_MISO(spi_MISO),
        .owner(owner), .busy(busy), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Waits for the launch, serves one frame of 'lat' XFER cycles and checks the done.
    task automatic serve(input logic eo, input logic [15:0] ec, input int ew,
                         input int lat, input logic [15:0] d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            inert_req = 1'b0;
            a2d_req   = 1'b0;
        end while (wrt !== 1'b1 && n < 64);
        chk("wrt_latency", n, ew);
        chk("launch_cmd", cmd, ec);
        chk("launch_owner", owner, eo);
        chk("launch_busy", busy, 1);
        spi_SS_n = 1'b0;
        #1;
        chk("sel_ss", eo ? A2D_SS_n : INERT_SS_n, 0);
        chk("other_ss", eo ? INERT_SS_n : A2D_SS_n, 1);
        @(negedge clk);
        chk("wrt_single", wrt, 0);
        for (int i = 1; i < lat; i++) @(negedge clk);
        spi_done = 1'b1;
        spi_rd_data = d;
        @(negedge clk);
        spi_done = 1'b0;
        spi_SS_n = 1'b1;
        spi_rd_data = '0;
        chk("inert_done", inert_done, {31'd0, !eo});
        chk("a2d_done", a2d_done, {31'd0, eo});
        chk("done_rd_data", rd_data, d);
        $display("txn owner=%0d cmd=%h rd=%h wait=%0d", eo, ec, d, n);
    endtask

    task automatic settle();
        repeat (GAP + 2) @(negedge clk);
    endtask

    typedef struct {
        logic        ir;
        logic [15:0] ic;
        logic        ar;
        logic [15:0] ac;
        int          lat;
        logic [15:0] rd_i;
        logic [15:0] rd_a;
    } vec_t;

    vec_t vecs [3];

    // Reference-model state (random phase)
    longint      c, last_wrt, sdone, idle_from;
    bit          pend [2];
    bit          pb [2];
    logic [15:0] lc [2];
    int          starve;
    bit          own, grant_m, w, in_lx, ir_r, ar_r;
    logic [15:0] exp_cmd, exp_rd, txn_data, ic_r, ac_r;
    bit          ss_prev, mi_prev, ma_prev;
    int          cnt_done, cnt_wrt;

    initial begin
        rst_n = 1'b0;
        inert_req = 0; a2d_req = 0; inert_cmd = '0; a2d_cmd = '0;
        spi_done = 0; spi_rd_data = '0; spi_SS_n = 1; INERT_MISO = 0; A2D_MISO = 0;
        repeat (3) @(negedge clk);
        chk("rst_wrt", wrt, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_done", {inert_done, a2d_done}, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_owner", owner, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_ss", {INERT_SS_n, A2D_SS_n}, 2'b11);
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0] = '{1'b1, 16'hA5F0, 1'b0, 16'h0000, LONG_LAT, 16'h1234, 16'h0000};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 16'h0C3A, 5,        16'h0000, 16'hBEEF};
        vecs[2] = '{1'b1, 16'h1111, 1'b1, 16'h2222, 3,        16'h0102, 16'h0304};
        for (int v = 0; v < 3; v++) begin
            inert_req = vecs[v].ir; inert_cmd = vecs[v].ic;
            a2d_req   = vecs[v].ar; a2d_cmd   = vecs[v].ac;
            if (vecs[v].ir) serve(1'b0, vecs[v].ic, 2, vecs[v].lat, vecs[v].rd_i);
            if (vecs[v].ar) serve(1'b1, vecs[v].ac, vecs[v].ir ? GAP + 1 : 2, vecs[v].lat, vecs[v].rd_a);
            settle();
        end

        // Starvation: A2D waits through MAX_INERT_CONSEC inertial grants, then wins.
        inert_req = 1; inert_cmd = 16'h5000; a2d_req = 1; a2d_cmd = 16'hA2D0;
        for (int k = 0; k < MAXC; k++) begin
            serve(1'b0, 16'h5000 + 16'(k), (k == 0) ? 2 : GAP + 1, 2, 16'h6000 + 16'(k));
            inert_req = 1; inert_cmd = 16'h5001 + 16'(k);
        end
        serve(1'b1, 16'hA2D0, GAP + 1, 2, 16'h7777);
        serve(1'b0, 16'h5000 + 16'(MAXC), GAP + 1, 2, 16'h8888);
        settle();

        // Duplicate A2D request while pending: first cmd wins, only one done.
        a2d_req = 1; a2d_cmd = 16'h3C3C;
        @(negedge clk);
        a2d_cmd = 16'h7777;
        serve(1'b1, 16'h3C3C, 1, 4, 16'h4242);
        cnt_done = 0; cnt_wrt = 0;
        repeat (GAP + 8) begin
            @(negedge clk);
            cnt_done += int'(a2d_done); cnt_wrt += int'(wrt);
        end
        chk("dup_extra_done", cnt_done, 0);
        chk("dup_extra_wrt", cnt_wrt, 0);

`ifdef SPI_ARB_TIMEOUT_EN
        inert_req = 1; inert_cmd = 16'h0BAD;
        @(negedge clk);
        inert_req = 0;
        @(negedge clk);
        chk("to_wrt", wrt, 1);
        cnt_wrt = 0;
        do begin @(negedge clk); cnt_wrt++; end while (inert_done !== 1'b1 && cnt_wrt < 40);
        chk("to_latency", cnt_wrt, TOUT + 1);
        chk("to_err", err, 1);
        chk("to_rd_data", rd_data, 16'hDEAD);
        $display("txn timeout owner=0 rd=%h", rd_data);
        settle();
`endif

        // Reset in the middle of an A2D transfer.
        a2d_req = 1; a2d_cmd = 16'h0F0F;
        @(negedge clk);
        a2d_req = 0;
        @(negedge clk);
        chk("mid_wrt", wrt, 1);
        repeat (3) @(negedge clk);
        spi_SS_n = 0;
        #1;
        chk("mid_ss_route", A2D_SS_n, 0);
        rst_n = 0;
        #1;
        chk("mid_rst_ss", A2D_SS_n, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rd", rd_data, 0);
        chk("mid_rst_owner", owner, 0);
        @(negedge clk);
        rst_n = 1; spi_done = 1; spi_SS_n = 1;
        cnt_done = 0; cnt_wrt = 0;
        repeat (8) begin
            @(negedge clk);
            spi_done = 0;
            cnt_done += int'(a2d_done) + int'(inert_done); cnt_wrt += int'(wrt);
        end
        chk("mid_no_done", cnt_done, 0);
        chk("mid_no_wrt", cnt_wrt, 0);
        $display("txn reset-abort checked");

        // Randomized traffic against the reference model.
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        pend[0] = 0; pend[1] = 0; lc[0] = '0; lc[1] = '0; starve = 0; own = 0;
        last_wrt = BIG; sdone = BIG; idle_from = 0;
        exp_cmd = '0; exp_rd = '0; txn_data = '0;
        ss_prev = 1; mi_prev = 0; ma_prev = 0;
        for (c = 1; c <= 3000; c++) begin
            @(negedge clk);
            if (c == sdone + 1) exp_rd = txn_data;
            in_lx = (c >= last_wrt) && (c <= sdone);
            chk("r_wrt", wrt, {31'd0, c == last_wrt});
            chk("r_inert_done", inert_done, {31'd0, (c == sdone + 1) && !own});
            chk("r_a2d_done", a2d_done, {31'd0, (c == sdone + 1) && own});
            chk("r_owner", owner, {31'd0, own});
            chk("r_busy", busy, {31'd0, (c >= last_wrt) && (c < idle_from)});
            chk("r_cmd", cmd, exp_cmd);
            chk("r_rd_data", rd_data, exp_rd);
            chk("r_inert_ss", INERT_SS_n, (in_lx && !own) ? ss_prev : 1'b1);
            chk("r_a2d_ss", A2D_SS_n, (in_lx && own) ? ss_prev : 1'b1);
            chk("r_miso", spi_MISO, own ? ma_prev : mi_prev);
            chk("r_err", err, 0);
            if (c == sdone + 1) $display("txn rand owner=%0d rd=%h cyc=%0d", own, txn_data, c);

            pb = pend;
            grant_m = (c >= idle_from) && (pb[0] || pb[1]);
            w = pb[1] && (!pb[0] || starve == MAXC);
            if (!pb[1]) starve = 0;
            else if (grant_m) starve = w ? 0 : ((starve < MAXC) ? starve + 1 : starve);
            if (c == last_wrt) pend[own] = 0;
            if (grant_m) begin
                own = w; exp_cmd = lc[w];
                last_wrt = c + 1; idle_from = BIG;
                sdone = c + 1 + longint'($urandom_range(1, 6));
                txn_data = 16'($urandom);
            end

            ss_prev = 1'($urandom); mi_prev = 1'($urandom); ma_prev = 1'($urandom);
            spi_SS_n = ss_prev; INERT_MISO = mi_prev; A2D_MISO = ma_prev;
            if (c == sdone) begin
                spi_done = 1; spi_rd_data = txn_data;
                idle_from = sdone + 1 + GAP;
            end else begin
                spi_done = !((c >= last_wrt) && (c <= sdone)) && ($urandom_range(0, 9) == 0);
                spi_rd_data = 16'($urandom);
            end

            ir_r = ($urandom_range(0, 3) == 0); ic_r = 16'($urandom);
            ar_r = ($urandom_range(0, 3) == 0); ac_r = 16'($urandom);
            inert_req = ir_r; inert_cmd = ic_r; a2d_req = ar_r; a2d_cmd = ac_r;
            if (ir_r && !pb[0] && !(in_lx && !own)) begin pend[0] = 1; lc[0] = ic_r; end
            if (ar_r && !pb[1] && !(in_lx && own)) begin pend[1] = 1; lc[1] = ac_r; end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_arb.md
Name: spi_arb

Overview:
- Arbitrates one 16-bit SPI master (wrt/cmd/done/rd_data) between two requesters: the inertial interface (requester 0) and the A2D interface (requester 1).
- Sequences each transaction: launch, wait for done, return data, then enforce an inter-frame SS_n gap.
- Routes the master's SS_n to the owning slave and muxes the owning slave's MISO back to the master.
- Sits at Segway top level between inert_intf, A2D_intf and a single shared SPI master.

Parameters:
- GAP_CYC, 4: idle cycles forced between transactions (0 allowed).
- MAX_INERT_CONSEC, 4: consecutive inertial grants allowed while an A2D request is pending.
- TIMEOUT_CYC, 4096: XFER watchdog limit; used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- inert_req  in  1  single-cycle request pulse from inertial interface.
- inert_cmd  in  16  command; sampled with inert_req.
- inert_done  out  1  single-cycle completion pulse to inertial interface.
- a2d_req  in  1  single-cycle request pulse from A2D interface.
- a2d_cmd  in  16  command; sampled with a2d_req.
- a2d_done  out  1  single-cycle completion pulse to A2D interface.
- rd_data  out  16  registered read data; valid in the cycle of either done pulse and held until the next done.
- wrt  out  1  launch pulse to SPI master.
- cmd  out  16  command to SPI master.
- spi_done  in  1  completion from SPI master.
- spi_rd_data  in  16  read data from SPI master.
- spi_SS_n  in  1  slave select from SPI master.
- INERT_SS_n  out  1  slave select to inertial sensor.
- A2D_SS_n  out  1  slave select to A2D.
- INERT_MISO  in  1  serial data from inertial sensor.
- A2D_MISO  in  1  serial data from A2D.
- spi_MISO  out  1  muxed serial data to SPI master.
- owner  out  1  current/last grantee: 0 = inertial, 1 = A2D.
- busy  out  1  high in LAUNCH, XFER and GAP.
- err  out  1  timeout pulse; tied 0 without the macro.

Behaviour:
- Reset: state IDLE; wrt=0, cmd=0, inert_done=0, a2d_done=0, rd_data=0, owner=0, busy=0, err=0. Pending flags, latched commands and all counters are cleared.
- Reset mid-transaction: return to IDLE immediately; no done pulse is ever issued for the aborted transaction.
- Request capture: a req pulse sets that requester's pending flag and latches its cmd. It is accepted only if pending is clear and the requester is not the owner in LAUNCH/XFER; otherwise it is ignored and the latched cmd is unchanged.
- A req in the same cycle as that requester's done pulse is accepted.
- States:
  - IDLE: if any pending, pick a winner, set owner, drive cmd, go to LAUNCH. Otherwise stay.
  - LAUNCH: wrt=1 for exactly one cycle; clear the winner's pending flag; go to XFER.
  - XFER: wait for spi_done. On spi_done at cycle k: rd_data<=spi_rd_data, and the owner's done pulses at k+1. Then go to GAP if GAP_CYC>0, else IDLE.
  - GAP: count GAP_CYC cycles, then go to IDLE.
- Latency: a req pulse into an idle arbiter with no other pending request produces wrt 2 cycles later.
- Pick rule: inertial wins when both are pending, unless the starvation counter equals MAX_INERT_CONSEC; then A2D wins.
- Starvation counter: +1 on each inertial grant while A2D is pending; cleared on an A2D grant or when A2D is not pending; saturates at MAX_INERT_CONSEC.
- Routing (combinational):
  - INERT_SS_n = spi_SS_n when owner=0 and state is LAUNCH or XFER, else 1.
  - A2D_SS_n is symmetric for owner=1.
  - spi_MISO = owner ? A2D_MISO : INERT_MISO.
- Stray spi_done outside XFER is ignored.

Optional Feature:
- SPI_ARB_TIMEOUT_EN defined:
  - Watchdog counter runs in XFER.
  - At TIMEOUT_CYC cycles without spi_done: rd_data<=16'hDEAD, owner's done and err pulse together, then go to GAP.
- Undefined: XFER waits indefinitely; err is constant 0.

Decomposition:
- Package spi_arb_pkg holds:
  - State enum (IDLE, LAUNCH, XFER, GAP).
  - OWN_INERT=1'b0, OWN_A2D=1'b1.
  - TIMEOUT_DATA=16'hDEAD.
- One sub-module, spi_arb_pick: combinational priority select plus the starvation counter register.

Test Plan:
- Reset mid-XFER (owner=1) -> A2D_SS_n=1, no a2d_done, state IDLE, rd_data=0.
- Single inert_req, cmd=16'hA5F0, spi_done after 32 cycles with spi_rd_data=16'h1234 -> wrt 2 cycles after req, cmd=A5F0, INERT_SS_n follows spi_SS_n, A2D_SS_n=1, inert_done + rd_data=1234 one cycle after spi_done.
- Both requests in the same cycle -> inertial served first; A2D wrt exactly GAP_CYC+1 cycles after inert_done.
- Continuous inertial requests with A2D pending, MAX_INERT_CONSEC=4 -> the 5th grant goes to A2D.
- Duplicate a2d_req while A2D is pending with a different cmd -> the original cmd is issued; only one a2d_done.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, no spi_done -> inert_done and err pulse at cycle 16 of XFER, rd_data=16'hDEAD.
